axi_reg_bank: RTL and testbench
===============================

// Module: axi_reg_bank
// PURPOSE
//  Parametrised AXI4-Lite slave register bank that replaces per-register macro instantiation.
//  Holds NumRegs_Gen registers described by a table of Axi_Reg_Type entries (addr, mask, type, reset).
//  Adds byte strobes, decode errors, hardware status/sticky inputs and per-register access pulses.
//  Sits between the AXI interconnect and any Time Card core (clock, PPS, signal TS units).
// PARAMETERS
//  NumRegs_Gen      8          number of registers in the bank (1..64)
//  RegDefs_Gen      all None_E Axi_Reg_Type [NumRegs_Gen-1:0]: per-register addr/mask/type/reset
//  AddrMask_Gen     32'h0000FFFF  address bits compared; all other bits are ignored
// PORTS
//  SysClk_ClkIn          in   1        system clock; the block is single-clock
//  SysRst_RstIn          in   1        synchronous reset, active-high
//  AxiWriteAddr*         io   AW ch.   Valid/Ready/Address[31:0]/Prot[2:0]
//  AxiWriteData*         io   W ch.    Valid/Ready/Data[31:0]/Strobe[3:0]
//  AxiWriteResp*         io   B ch.    Valid/Ready/Response[1:0]
//  AxiReadAddr*          io   AR ch.   Valid/Ready/Address[31:0]/Prot[2:0]
//  AxiReadData*          io   R ch.    Valid/Ready/Response[1:0]/Data[31:0]
//  RegValue_DatOut       out  32*N     current stored value of each register, masked
//  RegStatus_DatIn       in   32*N     hardware value returned for Ro_E registers
//  RegSet_DatIn          in   32*N     per-bit sticky set for Rc_E/Wc_E registers (level, per cycle)
//  RegWrite_EvtOut       out  N        1-cycle pulse on a successful write to register i
//  RegRead_EvtOut        out  N        1-cycle pulse on a successful read of register i
// BEHAVIOUR
//  Reset: all Ready/Valid low, Response=2'b00, ReadData=0, pulses low, Reg[i]=Reset&Mask, FSM=Idle_St.
//  FSM Axi_AccessState_Type: Idle_St -> Write_St | Read_St -> Resp_St -> Idle_St.
//  Idle_St: AW and W both valid -> assert both Readys for 1 cycle, go Write_St (AW/W taken together only).
//    Else AR valid -> ARReady for 1 cycle, go Read_St. Simultaneous read+write: write first, read next.
//  Decode: match (Address & AddrMask_Gen)>>2 vs (Addr & AddrMask_Gen)>>2; duplicates: lowest index wins.
//  Write_St (1 cycle): ByteMask = {8{Strb[3]},..,{8{Strb[0]}}}; M = Mask & ByteMask.
//    Rw_E/Wo_E: Reg = (Reg & ~M) | (Data & M).  Wc_E: Reg = Reg & ~(Data & M) (write-1-to-clear).
//    Ro_E/Rc_E/None_E: no change, resp SLVERR 2'b10. Unmapped: DECERR 2'b11. Else OKAY 2'b00.
//    RegWrite_EvtOut[i] pulses only on OKAY. Next cycle BValid=1, held until BReady.
//  Read_St (1 cycle): Ro_E returns RegStatus_DatIn[i]&Mask; Rw_E/Wc_E/Rc_E return Reg&Mask.
//    Rc_E: Reg = Reg & ~Mask (clear-on-read). Wo_E/None_E: SLVERR, data 0. Unmapped: DECERR, data 0.
//    Next cycle RValid=1 with data latched, held stable until RReady.
//  Sticky set: every cycle Reg |= RegSet_DatIn[i] & Mask for Rc_E/Wc_E; set beats clear in same cycle.
//  Latency: addr accepted cycle N -> register effect N+1 -> BValid/RValid N+2; back-to-back every 3 cycles min.
//  Resp_St: hold Valid until Ready; Readys stay low; new requests wait in Idle_St.
//  Reset mid-transaction: transaction dropped, no response; registers return to reset values.
//  Prot ignored. Address low bits [1:0] ignored. Ready never asserted outside Idle_St.
// STRUCTURE
//  timecard_package: Axi_AccessState_Type, Axi_RegType_Type, Axi_Reg_Type, Axi_Resp*_Con,
//    add function Axi_StrbToMask(strb[3:0]) -> [31:0] and Axi_RegDefArr typedef helper.
//  Sub-module axi_reg_cell (one per register, generate loop): holds Reg, applies write/clear/set
//    from decoded strobes; bank top holds FSM, decode, response mux.
//  Elaboration: $error if two RegDefs share an address or NumRegs_Gen out of range.
// TESTING
//  Reset, read all 4 regs (Rw 0x0 rst 0x12345678 mask 0xFFFF_FFFF) -> RData=0x12345678, RResp=00.
//  Write 0xAABBCCDD strobe 4'b0101 to Rw reg holding 0x11223344 -> reads back 0x11BB33DD, BResp=00.
//  Rc reg, RegSet bit3 pulse -> read 0x8 OKAY, second read 0x0; set+read same cycle -> next read 0x8.
//  Wc reg=0xF, write 0x5 -> 0xA; write to Ro reg -> BResp=10, value unchanged, no RegWrite pulse.
//  Read address 0x100 (unmapped) -> RResp=11, RData=0; write 0x100 -> BResp=11.
//  AW,W,AR valid same cycle, BReady held low 5 cycles -> BValid stays, AR served only after B done.

Source files
------------

// File: rtl/timecard_package.sv
// Shared AXI4-Lite register-bank types: access FSM states, register kinds, register
// descriptors, response codes and strobe/type helper functions.
package timecard_package;

   typedef enum logic [1:0] {
      Idle_St,
      Write_St,
      Read_St,
      Resp_St
   } Axi_AccessState_Type;

   typedef enum logic [2:0] {
      None_E,
      Rw_E,
      Ro_E,
      Wo_E,
      Rc_E,
      Wc_E
   } Axi_RegType_Type;

   typedef struct packed {
      logic [31:0]     Addr;
      logic [31:0]     Mask;
      Axi_RegType_Type RegType;
      logic [31:0]     Reset;
   } Axi_Reg_Type;

   localparam int Axi_MaxRegs_Con = 64;
   typedef Axi_Reg_Type [Axi_MaxRegs_Con-1:0] Axi_RegDefArr;

   localparam logic [1:0] Axi_RespOkay_Con   = 2'b00;
   localparam logic [1:0] Axi_RespSlvErr_Con = 2'b10;
   localparam logic [1:0] Axi_RespDecErr_Con = 2'b11;

   function automatic logic [31:0] Axi_StrbToMask(input logic [3:0] strb);
      return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
   endfunction

   function automatic logic Axi_IsWritable(input Axi_RegType_Type t);
      return (t == Rw_E) || (t == Wo_E) || (t == Wc_E);
   endfunction

   function automatic logic Axi_IsReadable(input Axi_RegType_Type t);
      return (t == Rw_E) || (t == Ro_E) || (t == Rc_E) || (t == Wc_E);
   endfunction

endpackage

// File: rtl/axi_reg_cell.sv
// One register of the bank: applies byte-masked writes, write-1-to-clear, clear-on-read
// and sticky hardware set; a sticky set wins over a clear landing in the same cycle.
module axi_reg_cell
   import timecard_package::*;
#(
   parameter logic [31:0]     Mask_Gen  = 32'hFFFF_FFFF,
   parameter logic [31:0]     Reset_Gen = 32'h0,
   parameter Axi_RegType_Type Type_Gen  = None_E
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [31:0] wr_dat,
   input  logic [31:0] wr_byte_mask,
   input  logic        rd_clr,
   input  logic [31:0] set_dat,
   output logic [31:0] reg_value
);

   localparam logic IsSticky = (Type_Gen == Rc_E) || (Type_Gen == Wc_E);
   localparam logic IsW1c    = (Type_Gen == Wc_E);

   logic [31:0] reg_q, reg_d;
   logic [31:0] wr_mask;

   always_comb begin
      wr_mask = Mask_Gen & wr_byte_mask;
      reg_d   = reg_q;
      if (wr_en) begin
         if (IsW1c) reg_d = reg_q & ~(wr_dat & wr_mask);
         else       reg_d = (reg_q & ~wr_mask) | (wr_dat & wr_mask);
      end
      if (rd_clr) reg_d = reg_d & ~Mask_Gen;
      // applied last so a set always survives a same-cycle clear
      if (IsSticky) reg_d = reg_d | (set_dat & Mask_Gen);
   end

   always_ff @(posedge clk) begin
      if (rst) reg_q <= Reset_Gen & Mask_Gen;
      else     reg_q <= reg_d;
   end

   assign reg_value = reg_q & Mask_Gen;

endmodule

// File: rtl/axi_reg_bank.sv
// AXI4-Lite slave register bank: one transaction at a time, accept -> effect +1 -> B/R valid +2.
// Readys only in Idle_St; B/R valid held until the master's ready, so new requests wait.
module axi_reg_bank
   import timecard_package::*;
#(
   parameter int                           NumRegs_Gen  = 8,
   parameter Axi_Reg_Type [NumRegs_Gen-1:0] RegDefs_Gen = '0,
   parameter logic [31:0]                  AddrMask_Gen = 32'h0000FFFF
) (
   input  logic                      SysClk_ClkIn,
   input  logic                      SysRst_RstIn,
   input  logic                      AxiWriteAddrValid_ValIn,
   output logic                      AxiWriteAddrReady_RdyOut,
   input  logic [31:0]               AxiWriteAddrAddress_AdrIn,
   input  logic [2:0]                AxiWriteAddrProt_DatIn,
   input  logic                      AxiWriteDataValid_ValIn,
   output logic                      AxiWriteDataReady_RdyOut,
   input  logic [31:0]               AxiWriteDataData_DatIn,
   input  logic [3:0]                AxiWriteDataStrobe_DatIn,
   output logic                      AxiWriteRespValid_ValOut,
   input  logic                      AxiWriteRespReady_RdyIn,
   output logic [1:0]                AxiWriteRespResponse_DatOut,
   input  logic                      AxiReadAddrValid_ValIn,
   output logic                      AxiReadAddrReady_RdyOut,
   input  logic [31:0]               AxiReadAddrAddress_AdrIn,
   input  logic [2:0]                AxiReadAddrProt_DatIn,
   output logic                      AxiReadDataValid_ValOut,
   input  logic                      AxiReadDataReady_RdyIn,
   output logic [1:0]                AxiReadDataResponse_DatOut,
   output logic [31:0]               AxiReadDataData_DatOut,
   output logic [32*NumRegs_Gen-1:0] RegValue_DatOut,
   input  logic [32*NumRegs_Gen-1:0] RegStatus_DatIn,
   input  logic [32*NumRegs_Gen-1:0] RegSet_DatIn,
   output logic [NumRegs_Gen-1:0]    RegWrite_EvtOut,
   output logic [NumRegs_Gen-1:0]    RegRead_EvtOut
);

   if (NumRegs_Gen < 1 || NumRegs_Gen > Axi_MaxRegs_Con) begin : g_bad_num
      $error("axi_reg_bank: NumRegs_Gen out of range 1..64");
   end
   // unused (None_E) entries may share an address without complaint
   for (genvar i = 0; i < NumRegs_Gen; i++) begin : g_chk_i
      for (genvar j = i + 1; j < NumRegs_Gen; j++) begin : g_chk_j
         if (RegDefs_Gen[i].RegType != None_E && RegDefs_Gen[j].RegType != None_E &&
             ((RegDefs_Gen[i].Addr & AddrMask_Gen) >> 2) == ((RegDefs_Gen[j].Addr & AddrMask_Gen) >> 2)) begin : g_dup
            $error("axi_reg_bank: duplicate register address");
         end
      end
   end

   wire unused_prot = ^{AxiWriteAddrProt_DatIn, AxiReadAddrProt_DatIn};

   Axi_AccessState_Type    state_q, state_d;
   logic [31:0]            addr_q, addr_d, wdat_q, wdat_d, rdata_q, rdata_d;
   logic [3:0]             strb_q, strb_d;
   logic                   bvld_q, bvld_d, rvld_q, rvld_d;
   logic [1:0]             bresp_q, bresp_d, rresp_q, rresp_d;
   logic [NumRegs_Gen-1:0] wr_evt_q, wr_evt_d, rd_evt_q, rd_evt_d;
   logic [NumRegs_Gen-1:0] sel_oh, wr_en, rd_clr;
   logic                   sel_hit, aw_rdy, ar_rdy;
   Axi_RegType_Type        sel_type;
   logic [31:0]            sel_mask, sel_val, sel_status, byte_mask;

   assign byte_mask = Axi_StrbToMask(strb_q);

   // first matching entry wins, so duplicates resolve to the lowest index
   always_comb begin
      sel_hit    = 1'b0;
      sel_oh     = '0;
      sel_type   = None_E;
      sel_mask   = '0;
      sel_val    = '0;
      sel_status = '0;
      for (int i = 0; i < NumRegs_Gen; i++) begin
         if (!sel_hit && (((addr_q & AddrMask_Gen) >> 2) == ((RegDefs_Gen[i].Addr & AddrMask_Gen) >> 2))) begin
            sel_hit    = 1'b1;
            sel_oh[i]  = 1'b1;
            sel_type   = RegDefs_Gen[i].RegType;
            sel_mask   = RegDefs_Gen[i].Mask;
            sel_val    = RegValue_DatOut[i*32 +: 32];
            sel_status = RegStatus_DatIn[i*32 +: 32];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdat_d   = wdat_q;
      strb_d   = strb_q;
      bvld_d   = bvld_q;
      rvld_d   = rvld_q;
      bresp_d  = bresp_q;
      rresp_d  = rresp_q;
      rdata_d  = rdata_q;
      wr_evt_d = '0;
      rd_evt_d = '0;
      wr_en    = '0;
      rd_clr   = '0;
      aw_rdy   = 1'b0;
      ar_rdy   = 1'b0;
      case (state_q)
         Idle_St: begin
            if (AxiWriteAddrValid_ValIn && AxiWriteDataValid_ValIn) begin
               aw_rdy  = 1'b1;
               addr_d  = AxiWriteAddrAddress_AdrIn;
               wdat_d  = AxiWriteDataData_DatIn;
               strb_d  = AxiWriteDataStrobe_DatIn;
               state_d = Write_St;
            end else if (AxiReadAddrValid_ValIn) begin
               ar_rdy  = 1'b1;
               addr_d  = AxiReadAddrAddress_AdrIn;
               state_d = Read_St;
            end
         end
         Write_St: begin
            state_d = Resp_St;
            bvld_d  = 1'b1;
            if (!sel_hit) begin
               bresp_d = Axi_RespDecErr_Con;
            end else if (Axi_IsWritable(sel_type)) begin
               bresp_d  = Axi_RespOkay_Con;
               wr_en    = sel_oh;
               wr_evt_d = sel_oh;
            end else begin
               bresp_d = Axi_RespSlvErr_Con;
            end
         end
         Read_St: begin
            state_d = Resp_St;
            rvld_d  = 1'b1;
            rdata_d = '0;
            if (!sel_hit) begin
               rresp_d = Axi_RespDecErr_Con;
            end else if (Axi_IsReadable(sel_type)) begin
               rresp_d  = Axi_RespOkay_Con;
               rdata_d  = ((sel_type == Ro_E) ? sel_status : sel_val) & sel_mask;
               rd_evt_d = sel_oh;
               if (sel_type == Rc_E) rd_clr = sel_oh;
            end else begin
               rresp_d = Axi_RespSlvErr_Con;
            end
         end
         Resp_St: begin
            if ((bvld_q && AxiWriteRespReady_RdyIn) || (rvld_q && AxiReadDataReady_RdyIn)) begin
               bvld_d  = 1'b0;
               rvld_d  = 1'b0;
               state_d = Idle_St;
            end
         end
         default: state_d = Idle_St;
      endcase
   end

   always_ff @(posedge SysClk_ClkIn) begin
      if (SysRst_RstIn) begin
         state_q  <= Idle_St;
         addr_q   <= '0;
         wdat_q   <= '0;
         strb_q   <= '0;
         bvld_q   <= 1'b0;
         rvld_q   <= 1'b0;
         bresp_q  <= Axi_RespOkay_Con;
         rresp_q  <= Axi_RespOkay_Con;
         rdata_q  <= '0;
         wr_evt_q <= '0;
         rd_evt_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdat_q   <= wdat_d;
         strb_q   <= strb_d;
         bvld_q   <= bvld_d;
         rvld_q   <= rvld_d;
         bresp_q  <= bresp_d;
         rresp_q  <= rresp_d;
         rdata_q  <= rdata_d;
         wr_evt_q <= wr_evt_d;
         rd_evt_q <= rd_evt_d;
      end
   end

   for (genvar g = 0; g < NumRegs_Gen; g++) begin : g_cell
      axi_reg_cell #(
         .Mask_Gen  (RegDefs_Gen[g].Mask),
         .Reset_Gen (RegDefs_Gen[g].Reset),
         .Type_Gen  (RegDefs_Gen[g].RegType)
      ) u_cell (
         .clk          (SysClk_ClkIn),
         .rst          (SysRst_RstIn),
         .wr_en        (wr_en[g]),
         .wr_dat       (wdat_q),
         .wr_byte_mask (byte_mask),
         .rd_clr       (rd_clr[g]),
         .set_dat      (RegSet_DatIn[g*32 +: 32]),
         .reg_value    (RegValue_DatOut[g*32 +: 32])
      );
   end

   assign AxiWriteAddrReady_RdyOut    = aw_rdy;
   assign AxiWriteDataReady_RdyOut    = aw_rdy;
   assign AxiReadAddrReady_RdyOut     = ar_rdy;
   assign AxiWriteRespValid_ValOut    = bvld_q;
   assign AxiWriteRespResponse_DatOut = bresp_q;
   assign AxiReadDataValid_ValOut     = rvld_q;
   assign AxiReadDataResponse_DatOut  = rresp_q;
   assign AxiReadDataData_DatOut      = rdata_q;
   assign RegWrite_EvtOut             = wr_evt_q;
   assign RegRead_EvtOut              = rd_evt_q;

endmodule

// File: tb/tb_axi_reg_bank.sv
// Directed bench for axi_reg_bank: vector table of single accesses plus hand-timed
// sequences for sticky set vs clear-on-read, write/read arbitration and mid-transaction reset.
module tb_axi_reg_bank;
   import timecard_package::*;

   localparam int N = 6;
   localparam Axi_Reg_Type R0 = '{Addr: 32'h00, Mask: 32'hFFFF_FFFF, RegType: Rw_E, Reset: 32'h1234_5678};
   localparam Axi_Reg_Type R1 = '{Addr: 32'h04, Mask: 32'h0000_00FF, RegType: Rc_E, Reset: 32'h0};
   localparam Axi_Reg_Type R2 = '{Addr: 32'h08, Mask: 32'h0000_00FF, RegType: Wc_E, Reset: 32'h0F};
   localparam Axi_Reg_Type R3 = '{Addr: 32'h0C, Mask: 32'h0000_FFFF, RegType: Ro_E, Reset: 32'h0};
   localparam Axi_Reg_Type R4 = '{Addr: 32'h10, Mask: 32'hFFFF_FFFF, RegType: Wo_E, Reset: 32'h0};
   localparam Axi_Reg_Type R5 = '{Addr: 32'h14, Mask: 32'h0000_FF0F, RegType: Rw_E, Reset: 32'hFFFF_FFFF};
   localparam Axi_Reg_Type [N-1:0] DEFS = {R5, R4, R3, R2, R1, R0};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          aw_vld = 0, w_vld = 0, b_rdy = 0, ar_vld = 0, r_rdy = 0;
   logic          aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
   logic [31:0]   aw_addr = 0, w_data = 0, ar_addr = 0, r_data;
   logic [3:0]    w_strb = 0;
   logic [2:0]    aw_prot = 0, ar_prot = 0;
   logic [1:0]    b_resp, r_resp;
   logic [32*N-1:0] reg_value;
   logic [32*N-1:0] reg_status = '0;
   logic [32*N-1:0] reg_set = '0;
   logic [N-1:0]  wr_evt, rd_evt;

   axi_reg_bank #(.NumRegs_Gen(N), .RegDefs_Gen(DEFS), .AddrMask_Gen(32'h0000FFFF)) dut (
      .SysClk_ClkIn                (clk),
      .SysRst_RstIn                (rst),
      .AxiWriteAddrValid_ValIn     (aw_vld),
      .AxiWriteAddrReady_RdyOut    (aw_rdy),
      .AxiWriteAddrAddress_AdrIn   (aw_addr),
      .AxiWriteAddrProt_DatIn      (aw_prot),
      .AxiWriteDataValid_ValIn     (w_vld),
      .AxiWriteDataReady_RdyOut    (w_rdy),
      .AxiWriteDataData_DatIn      (w_data),
      .AxiWriteDataStrobe_DatIn    (w_strb),
      .AxiWriteRespValid_ValOut    (b_vld),
      .AxiWriteRespReady_RdyIn     (b_rdy),
      .AxiWriteRespResponse_DatOut (b_resp),
      .AxiReadAddrValid_ValIn      (ar_vld),
      .AxiReadAddrReady_RdyOut     (ar_rdy),
      .AxiReadAddrAddress_AdrIn    (ar_addr),
      .AxiReadAddrProt_DatIn       (ar_prot),
      .AxiReadDataValid_ValOut     (r_vld),
      .AxiReadDataReady_RdyIn      (r_rdy),
      .AxiReadDataResponse_DatOut  (r_resp),
      .AxiReadDataData_DatOut      (r_data),
      .RegValue_DatOut             (reg_value),
      .RegStatus_DatIn             (reg_status),
      .RegSet_DatIn                (reg_set),
      .RegWrite_EvtOut             (wr_evt),
      .RegRead_EvtOut              (rd_evt)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [N-1:0] ev);
      bit got;
      ev = '0;
      resp = 2'b01;
      aw_addr = a; w_data = d; w_strb = s;
      aw_vld = 1; w_vld = 1; b_rdy = 1;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         ev |= wr_evt;
         if (aw_rdy && w_rdy) got = 1;
      end
      check("aw_w_accept", 32'(got), 32'd1);
      @(posedge clk); #1;
      aw_vld = 0; w_vld = 0;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         ev |= wr_evt;
         if (b_vld) begin got = 1; resp = b_resp; end
      end
      check("b_valid_seen", 32'(got), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [1:0] resp,
                          output logic [31:0] d, output logic [N-1:0] ev);
      bit got;
      ev = '0;
      resp = 2'b01;
      d = 32'hXXXX_XXXX;
      ar_addr = a; ar_vld = 1; r_rdy = 1;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         ev |= rd_evt;
         if (ar_rdy) got = 1;
      end
      check("ar_accept", 32'(got), 32'd1);
      @(posedge clk); #1;
      ar_vld = 0;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         ev |= rd_evt;
         if (r_vld) begin got = 1; resp = r_resp; d = r_data; end
      end
      check("r_valid_seen", 32'(got), 32'd1);
      @(posedge clk); #1;
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  resp;
      logic [31:0] rdata;
      logic [N-1:0] evt;
   } vec_t;

   vec_t vecs[17];
   logic [31:0] rst_exp[N];

   initial begin
      logic [1:0]   resp;
      logic [31:0]  d;
      logic [N-1:0] ev;
      bit           seen;

      vecs[0]  = '{0, 32'h0000_0000, 32'h0,         4'h0,    2'b00, 32'h1234_5678, 6'b000001};
      vecs[1]  = '{1, 32'h0000_0000, 32'h1122_3344, 4'hF,    2'b00, 32'h0,         6'b000001};
      vecs[2]  = '{1, 32'h0000_0000, 32'hAABB_CCDD, 4'b0101, 2'b00, 32'h0,         6'b000001};
      vecs[3]  = '{0, 32'h0000_0000, 32'h0,         4'h0,    2'b00, 32'h11BB_33DD, 6'b000001};
      vecs[4]  = '{0, 32'h0000_0003, 32'h0,         4'h0,    2'b00, 32'h11BB_33DD, 6'b000001};
      vecs[5]  = '{0, 32'hABCD_0000, 32'h0,         4'h0,    2'b00, 32'h11BB_33DD, 6'b000001};
      vecs[6]  = '{0, 32'h0000_000C, 32'h0,         4'h0,    2'b00, 32'h0000_BEEF, 6'b001000};
      vecs[7]  = '{1, 32'h0000_000C, 32'h1234,      4'hF,    2'b10, 32'h0,         6'b000000};
      vecs[8]  = '{0, 32'h0000_0010, 32'h0,         4'h0,    2'b10, 32'h0,         6'b000000};
      vecs[9]  = '{1, 32'h0000_0010, 32'hCAFE_F00D, 4'hF,    2'b00, 32'h0,         6'b010000};
      vecs[10] = '{1, 32'h0000_0008, 32'h0000_0005, 4'hF,    2'b00, 32'h0,         6'b000100};
      vecs[11] = '{0, 32'h0000_0008, 32'h0,         4'h0,    2'b00, 32'h0000_000A, 6'b000100};
      vecs[12] = '{1, 32'h0000_0014, 32'h0000_0000, 4'b0010, 2'b00, 32'h0,         6'b100000};
      vecs[13] = '{0, 32'h0000_0014, 32'h0,         4'h0,    2'b00, 32'h0000_000F, 6'b100000};
      vecs[14] = '{0, 32'h0000_0100, 32'h0,         4'h0,    2'b11, 32'h0,         6'b000000};
      vecs[15] = '{1, 32'h0000_0100, 32'h5555_5555, 4'hF,    2'b11, 32'h0,         6'b000000};
      vecs[16] = '{0, 32'h0000_0004, 32'h0,         4'h0,    2'b00, 32'h0,         6'b000010};
      rst_exp = '{32'h1234_5678, 32'h0, 32'h0F, 32'h0, 32'h0, 32'h0000_FF0F};

      reg_status[3*32 +: 32] = 32'hDEAD_BEEF;
      repeat (3) @(posedge clk);
      #1 rst = 0;

      @(negedge clk);
      check("rst_bvalid", 32'(b_vld), 32'd0);
      check("rst_rvalid", 32'(r_vld), 32'd0);
      check("rst_rdata", r_data, 32'd0);
      check("rst_resp", {28'd0, b_resp, r_resp}, 32'd0);
      check("rst_ready", {29'd0, aw_rdy, w_rdy, ar_rdy}, 32'd0);
      check("rst_evts", {20'd0, wr_evt, rd_evt}, 32'd0);
      for (int i = 0; i < N; i++)
         check($sformatf("rst_reg%0d", i), reg_value[i*32 +: 32], rst_exp[i]);
      @(posedge clk); #1;

      for (int i = 0; i < 17; i++) begin
         if (vecs[i].wr) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, ev);
            check($sformatf("v%0d_bresp", i), 32'(resp), 32'(vecs[i].resp));
            check($sformatf("v%0d_wr_evt", i), 32'(ev), 32'(vecs[i].evt));
         end else begin
            do_read(vecs[i].addr, resp, d, ev);
            check($sformatf("v%0d_rresp", i), 32'(resp), 32'(vecs[i].resp));
            check($sformatf("v%0d_rdata", i), d, vecs[i].rdata);
            check($sformatf("v%0d_rd_evt", i), 32'(ev), 32'(vecs[i].evt));
         end
      end
      check("ro_unchanged", reg_value[3*32 +: 32], 32'h0);
      check("wo_value", reg_value[4*32 +: 32], 32'hCAFE_F00D);
      check("wc_value", reg_value[2*32 +: 32], 32'h0000_000A);

      // sticky set pulse then clear-on-read
      reg_set[1*32 +: 32] = 32'h8;
      @(posedge clk); #1;
      reg_set[1*32 +: 32] = 32'h0;
      check("rc_set_value", reg_value[1*32 +: 32], 32'h8);
      do_read(32'h4, resp, d, ev);
      check("rc_read1_resp", 32'(resp), 32'd0);
      check("rc_read1_data", d, 32'h8);
      do_read(32'h4, resp, d, ev);
      check("rc_read2_data", d, 32'h0);

      // set lands in the very cycle the read clears: set must survive
      ar_addr = 32'h4; ar_vld = 1; r_rdy = 1;
      @(negedge clk);
      check("sc_ar_rdy", 32'(ar_rdy), 32'd1);
      @(posedge clk); #1;
      ar_vld = 0;
      reg_set[1*32 +: 32] = 32'h8;
      @(posedge clk); #1;
      reg_set[1*32 +: 32] = 32'h0;
      @(negedge clk);
      check("sc_rvalid", 32'(r_vld), 32'd1);
      check("sc_rdata", r_data, 32'h0);
      @(posedge clk); #1;
      do_read(32'h4, resp, d, ev);
      check("sc_next_read", d, 32'h8);
      do_read(32'h4, resp, d, ev);
      check("sc_after_clear", d, 32'h0);

      // AW+W+AR together, B held off for 5 cycles
      aw_addr = 32'h0; w_data = 32'h55AA_55AA; w_strb = 4'hF; ar_addr = 32'h0;
      aw_vld = 1; w_vld = 1; ar_vld = 1; b_rdy = 0; r_rdy = 0;
      @(negedge clk);
      check("arb_aw_rdy", 32'(aw_rdy), 32'd1);
      check("arb_ar_wait", 32'(ar_rdy), 32'd0);
      @(posedge clk); #1;
      aw_vld = 0; w_vld = 0;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("arb_bhold%0d", k), 32'(b_vld), 32'd1);
         check($sformatf("arb_ar_blocked%0d", k), 32'(ar_rdy), 32'd0);
      end
      check("arb_bresp", 32'(b_resp), 32'd0);
      b_rdy = 1;
      @(posedge clk); #1;
      b_rdy = 0;
      @(negedge clk);
      check("arb_ar_rdy", 32'(ar_rdy), 32'd1);
      @(posedge clk); #1;
      ar_vld = 0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("arb_rhold%0d", k), 32'(r_vld), 32'd1);
         check($sformatf("arb_rdata%0d", k), r_data, 32'h55AA_55AA);
      end
      r_rdy = 1;
      @(posedge clk); #1;
      r_rdy = 0;
      @(negedge clk);
      check("arb_r_done", 32'(r_vld), 32'd0);
      @(posedge clk); #1;

      // reset while a write is in flight: no response, registers back to reset values
      aw_addr = 32'h0; w_data = 32'h0; w_strb = 4'hF; aw_vld = 1; w_vld = 1; b_rdy = 1;
      @(negedge clk);
      check("mid_aw_rdy", 32'(aw_rdy), 32'd1);
      @(posedge clk); #1;
      aw_vld = 0; w_vld = 0; rst = 1;
      @(posedge clk); #1;
      rst = 0;
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (b_vld) seen = 1;
      end
      check("mid_no_bvalid", 32'(seen), 32'd0);
      check("mid_reg0", reg_value[0 +: 32], 32'h1234_5678);
      check("mid_reg2", reg_value[2*32 +: 32], 32'h0F);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
